// File: rtl/irq_controller.sv
// Interrupt source for the CPU: latches peripheral request edges as pending, applies an
// enable mask and fixed priority, and dispatches one interrupt at a time as a fixed-length pulse.
module irq_controller #(
  parameter int         PULSE_LEN  = 4,
  parameter logic [7:0] MASK_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irq_in,
  input  logic       mask_we,
  input  logic [7:0] mask_wdata,
  input  logic       reti,
  output logic [3:0] cpu_int,
  output logic [2:0] active_src,
  output logic       active_valid,
  output logic [7:0] pending,
  output logic [7:0] mask
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ASSERT    = 2'd1;
  localparam logic [1:0] S_WAIT_RETI = 2'd2;
  localparam logic [3:0] CNT_INIT    = 4'(PULSE_LEN - 1);

  logic [7:0] r_irq_prev;
  logic [7:0] r_pending;
  logic [7:0] r_mask;
  logic [1:0] r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_cpu_int;
  logic [2:0] r_active_src;
  logic       r_active_valid;

  logic [7:0] w_edge;
  logic [7:0] w_elig;
  logic [2:0] w_sel;
  logic       w_dispatch;

  assign w_edge     = irq_in & ~r_irq_prev;
  assign w_elig     = r_pending & r_mask;
  assign w_dispatch = (r_state == S_IDLE) && (w_elig != 8'h00);

  // Lowest set index wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    w_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_elig[i]) w_sel = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_prev <= 8'h00;
      r_pending  <= 8'h00;
      r_mask     <= MASK_RESET;
    end else begin
      r_irq_prev <= irq_in;
      // A fresh edge on the source being dispatched survives the clear.
      if (w_dispatch) r_pending <= (r_pending & ~(8'h01 << w_sel)) | w_edge;
      else            r_pending <= r_pending | w_edge;
      if (mask_we) r_mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= 4'd0;
      r_cpu_int      <= 4'b0000;
      r_active_src   <= 3'd0;
      r_active_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dispatch) begin
            r_active_src   <= w_sel;
            r_active_valid <= 1'b1;
            r_cpu_int      <= 4'b0001 << w_sel[2:1];
            r_cnt          <= CNT_INIT;
            r_state        <= S_ASSERT;
          end
        end
        S_ASSERT: begin
          if (r_cnt == 4'd0) begin
            r_cpu_int <= 4'b0000;
            r_state   <= S_WAIT_RETI;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_WAIT_RETI: begin
          if (reti) begin
            r_active_valid <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: begin
          r_cpu_int <= 4'b0000;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_int      = r_cpu_int;
  assign active_src   = r_active_src;
  assign active_valid = r_active_valid;
  assign pending      = r_pending;
  assign mask         = r_mask;

endmodule

// File: tb/tb_irq_controller.sv
// Randomized and directed bench for irq_controller against a time-since-dispatch reference model.
module tb_irq_controller;

  localparam int         PL = 4;
  localparam logic [7:0] MR = 8'h00;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       reti;
  logic [3:0] cpu_int;
  logic [2:0] active_src;
  logic       active_valid;
  logic [7:0] pending;
  logic [7:0] mask;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: pending/mask as plain bytes, service tracked as "busy" plus cycles since dispatch.
  logic [7:0] m_prev, m_pend, m_mask;
  bit         m_busy;
  int         m_age;
  int         m_src;

  irq_controller #(.PULSE_LEN(PL), .MASK_RESET(MR)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .reti(reti), .cpu_int(cpu_int),
    .active_src(active_src), .active_valid(active_valid),
    .pending(pending), .mask(mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_line();
    if (m_busy && m_age < PL) return 4'(1 << (m_src / 2));
    return 4'b0000;
  endfunction

  task automatic model_step();
    logic [7:0] e;
    e = irq_in & ~m_prev;
    if (reset) begin
      m_prev = 8'h00; m_pend = 8'h00; m_mask = MR;
      m_busy = 1'b0;  m_age  = 0;     m_src  = 0;
      return;
    end
    if (!m_busy && (m_pend & m_mask) != 8'h00) begin
      int s;
      s = 0;
      while (((m_pend & m_mask) >> s) % 2 == 0) s++;
      m_pend = m_pend & ~(8'h01 << s);
      m_busy = 1'b1;
      m_age  = 0;
      m_src  = s;
    end else if (m_busy) begin
      if (m_age >= PL) begin
        if (reti) m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end
    m_pend = m_pend | e;
    if (mask_we) m_mask = mask_wdata;
    m_prev = irq_in;
  endtask

  task automatic tick(input logic r, input logic [7:0] irq, input logic we,
                      input logic [7:0] wd, input logic rt);
    reset = r; irq_in = irq; mask_we = we; mask_wdata = wd; reti = rt;
    @(posedge clk);
    model_step();
    #1;
    check("cpu_int",      32'(cpu_int),      32'(m_line()));
    check("active_src",   32'(active_src),   32'(m_src));
    check("active_valid", 32'(active_valid), 32'(m_busy));
    check("pending",      32'(pending),      32'(m_pend));
    check("mask",         32'(mask),         32'(m_mask));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reti();
    tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    tick(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic write_mask(input logic [7:0] v);
    tick(1'b0, 8'h00, 1'b1, v, 1'b0);
  endtask

  initial begin
    int hi;
    logic [7:0] irq_r;
    m_prev = 8'h00; m_pend = 8'h00; m_mask = MR; m_busy = 1'b0; m_age = 0; m_src = 0;

    do_reset();
    check("reset_cpu_int", 32'(cpu_int), 32'h0);
    check("reset_mask", 32'(mask), 32'(MR));

    // Single source 5: pulse length and line mapping.
    write_mask(8'hFF);
    tick(1'b0, 8'h20, 1'b0, 8'h00, 1'b0);
    check("s5_pending", 32'(pending), 32'h20);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      if (i == 0) check("s5_first", 32'(cpu_int), 32'h4);
      if (cpu_int == 4'b0100) hi++;
    end
    check("s5_pulse_len", 32'(hi), 32'(PL));
    check("s5_src", 32'(active_src), 32'd5);
    check("s5_valid", 32'(active_valid), 32'd1);
    do_reti();
    check("s5_valid_clr", 32'(active_valid), 32'd0);

    // Priority: 1 before 6.
    tick(1'b0, 8'h42, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("prio_line", 32'(cpu_int), 32'h1);
    check("prio_src", 32'(active_src), 32'd1);
    check("prio_pend", 32'(pending), 32'h40);
    idle(6);
    do_reti();
    tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("prio2_line", 32'(cpu_int), 32'h8);
    check("prio2_src", 32'(active_src), 32'd6);
    idle(6);
    do_reti();

    // Masked source stays pending, dispatches once unmasked.
    write_mask(8'h00);
    tick(1'b0, 8'h08, 1'b0, 8'h00, 1'b0);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      if (cpu_int != 4'b0000) hi++;
    end
    check("masked_quiet", 32'(hi), 32'd0);
    check("masked_pend", 32'(pending), 32'h08);
    write_mask(8'h08);
    check("unmask_wait", 32'(cpu_int), 32'h0);
    tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("unmask_line", 32'(cpu_int), 32'h2);
    check("unmask_pend", 32'(pending), 32'h00);
    idle(6);
    do_reti();

    // Re-edge during WAIT_RETI is held until reti.
    write_mask(8'hFF);
    tick(1'b0, 8'h01, 1'b0, 8'h00, 1'b0);
    idle(6);
    tick(1'b0, 8'h01, 1'b0, 8'h00, 1'b0);
    idle(3);
    check("rewait_pend", 32'(pending), 32'h01);
    check("rewait_line", 32'(cpu_int), 32'h0);
    do_reti();
    check("rewait_reti", 32'(active_valid), 32'd0);
    tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("redispatch", 32'(cpu_int), 32'h1);

    // Reset mid-pulse.
    tick(1'b0, 8'h10, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    check("rst_line", 32'(cpu_int), 32'h0);
    check("rst_pend", 32'(pending), 32'h0);
    check("rst_valid", 32'(active_valid), 32'd0);
    check("rst_mask", 32'(mask), 32'(MR));

    // Early reti in IDLE is not remembered.
    write_mask(8'hFF);
    do_reti();
    tick(1'b0, 8'h04, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 8'hFF, 1'b1);
    idle(10);
    check("early_reti", 32'(active_valid), 32'd1);
    check("early_src", 32'(active_src), 32'd2);
    do_reti();
    check("late_reti", 32'(active_valid), 32'd0);

    // Randomized traffic against the model.
    irq_r = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] flip;
      flip = 8'h00;
      for (int b = 0; b < 8; b++) if ($urandom_range(7) == 0) flip[b] = 1'b1;
      irq_r = irq_r ^ flip;
      tick(($urandom_range(399) == 0), irq_r, ($urandom_range(15) == 0),
           8'($urandom), ($urandom_range(5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt source side of the CPU interrupt interface.
- Collects up to 8 peripheral interrupt requests and latches them as pending on their rising edge.
- Applies a software-writable enable mask and fixed priority, then drives the CPU's four interrupt lines with fixed-length pulses.
- Issues one interrupt at a time. It waits for the CPU's return-from-interrupt indication before dispatching the next one, so an edge is never lost while the CPU has interrupts disabled.
- Sits between the peripherals (UART, timers, GPU vsync, etc.) and the CPU core.

Parameters:
- PULSE_LEN, 4: number of clk cycles a cpu_int line is held high per dispatch. Legal range 2..15.
- MASK_RESET, 8'h00: reset value of the enable mask. Bit = 1 means the source is enabled.

Ports:
- clk  input  1  system clock. All state updates on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- irq_in  input  8  level requests from peripherals. A 0->1 transition sets the pending bit.
- mask_we  input  1  one-cycle write strobe for the enable mask.
- mask_wdata  input  8  new enable mask value.
- reti  input  1  one-cycle pulse from the CPU when a reti instruction retires.
- cpu_int  output  4  interrupt lines to the CPU. Source i drives line i>>1.
- active_src  output  3  index of the source currently being serviced. Software reads it to tell the two sources sharing a line apart.
- active_valid  output  1  high from dispatch until reti is received.
- pending  output  8  current pending register.
- mask  output  8  current enable mask.

Behaviour:
- Reset values:
  - cpu_int = 0, active_src = 0, active_valid = 0, pending = 0, mask = MASK_RESET.
  - Internal irq_prev = 0, pulse counter = 0, state = IDLE.
  - Reset mid-dispatch aborts immediately. cpu_int drops the cycle after reset is sampled. Pending edges are discarded.
- Edge detection:
  - irq_prev <= irq_in every cycle.
  - Any bit where irq_in & ~irq_prev is set goes into pending (sticky).
  - Edge detection and pending-set continue in every state, including reset release. irq_prev is 0 after reset, so a source held high through reset produces one edge on the first cycle after reset.
- Mask:
  - mask <= mask_wdata on mask_we.
  - Masked pending bits are kept, not cleared. They dispatch once unmasked.
- Eligible set: pending & mask. Priority is fixed, lowest index highest.
- FSM states: IDLE, ASSERT, WAIT_RETI.
  - IDLE: if the eligible set is non-zero, select the lowest set index s and, in the same cycle:
    - clear pending[s];
    - active_src <= s, active_valid <= 1;
    - cpu_int[s>>1] <= 1, all other lines 0;
    - counter <= PULSE_LEN-1;
    - go to ASSERT.
    - Dispatch latency: an edge on irq_in sampled at cycle N gives cpu_int high at cycle N+2 (N+1 sets pending, N+2 dispatches).
  - ASSERT: decrement the counter. When the counter is 0, set cpu_int <= 0 and go to WAIT_RETI. The line is high for exactly PULSE_LEN cycles.
  - WAIT_RETI: cpu_int stays 0. On reti = 1, set active_valid <= 0 and go to IDLE. The next dispatch can happen at the earliest one cycle after IDLE is entered.
  - A reti received in IDLE or ASSERT is ignored; it is not remembered.
- Simultaneous events:
  - A new edge on source s in the same cycle that s is dispatched (pending[s] cleared) leaves pending[s] = 1. Set wins over clear.
  - mask_we in the same cycle as a dispatch decision: the decision uses the old mask.
  - A source at a higher priority than the one in service does not preempt it. It stays pending until reti.
- cpu_int is registered only. It is glitch-free and stable across the falling edge at which the CPU samples it.
- Only one cpu_int bit is high at any time.

Test Plan:
- Reset, then mask_we with 8'hFF, then pulse irq_in[5] -> pending = 8'h20 for one cycle; cpu_int = 4'b0100 for exactly 4 cycles starting 2 cycles after the edge; active_src = 5; active_valid = 1 until reti.
- mask = 8'hFF, assert irq_in[6] and irq_in[1] in the same cycle -> source 1 dispatched first (cpu_int = 4'b0001, active_src = 1) and pending = 8'h40. After reti, source 6 dispatched (cpu_int = 4'b1000, active_src = 6).
- mask = 8'h00, pulse irq_in[3] -> pending = 8'h08 and no cpu_int activity for 20 cycles. Write mask 8'h08 -> cpu_int = 4'b0010 two cycles after the write; pending returns to 0.
- Dispatch source 0, then pulse irq_in[0] again during WAIT_RETI -> pending = 8'h01 and cpu_int stays 0 until reti. One cycle after returning to IDLE, source 0 is redispatched.
- Assert reset during ASSERT (counter mid-count) -> the next cycle cpu_int = 0, pending = 0, active_valid = 0, mask = MASK_RESET, and the FSM is in IDLE.
- Pulse reti in IDLE, then dispatch source 2 -> the earlier reti has no effect; active_valid stays 1 until a reti arrives while in WAIT_RETI.
